// File: rtl/lm_sm_seq_if.sv
// Execute-stage handshake plus register-file and data-memory ports used by the
// LM/SM sequencer. The sequencer takes the slave side.
interface lm_sm_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREG   = 8
);
    localparam int RIDX_W = $clog2(NREG);

    logic              start;
    logic              is_load;
    logic [NREG-1:0]   mask;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;

    logic [RIDX_W-1:0] rf_addr;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_wdata;

    modport slave (
        input  start, is_load, mask, base_addr, rf_rdata, mem_rdata,
        output busy, done, rf_addr, rf_we, rf_wdata,
               mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output start, is_load, mask, base_addr, rf_rdata, mem_rdata,
        input  busy, done, rf_addr, rf_we, rf_wdata,
               mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/lm_sm_seq.sv
// LM/SM multi-register transfer sequencer: walks the register mask lowest bit
// first, issuing one register access and one memory access per cycle.
module lm_sm_seq #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREG   = 8
) (
    input  logic          clk,
    input  logic          rst,
    lm_sm_seq_if.slave    bus
);
    localparam int RIDX_W = $clog2(NREG);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state;
    logic [NREG-1:0]   pending;
    logic [ADDR_W-1:0] addr;
    logic              is_load_q;
    logic              busy_q;
    logic              done_q;
    logic              rf_we_q;
    logic              mem_re_q;
    logic              mem_we_q;

    logic [RIDX_W-1:0] cur;
    logic [NREG-1:0]   pending_nxt;
    logic              last;

    // Priority encode: scanning high to low leaves the lowest set bit in cur.
    always_comb begin
        cur = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (pending[i]) cur = RIDX_W'(i);
        end
    end

    // x & (x-1) drops the lowest set bit; empty result means this is the final transfer.
    assign pending_nxt = pending & (pending - NREG'(1));
    assign last        = (pending_nxt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pending   <= '0;
            addr      <= '0;
            is_load_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rf_we_q   <= 1'b0;
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.mask != '0) begin
                            pending   <= bus.mask;
                            addr      <= bus.base_addr;
                            is_load_q <= bus.is_load;
                            state     <= XFER;
                            busy_q    <= 1'b1;
                            rf_we_q   <= bus.is_load;
                            mem_re_q  <= bus.is_load;
                            mem_we_q  <= !bus.is_load;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    pending <= pending_nxt;
                    addr    <= addr + ADDR_W'(1);
                    if (last) begin
                        state    <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        rf_we_q  <= 1'b0;
                        mem_re_q <= 1'b0;
                        mem_we_q <= 1'b0;
                    end else begin
                        rf_we_q  <= is_load_q;
                        mem_re_q <= is_load_q;
                        mem_we_q <= !is_load_q;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    rf_we_q  <= 1'b0;
                    mem_re_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rf_addr   = cur;
    assign bus.rf_we     = rf_we_q;
    assign bus.mem_addr  = addr;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    // Data paths are pure wires; the strobes decide which side is consumed.
    assign bus.rf_wdata  = bus.mem_rdata;
    assign bus.mem_wdata = bus.rf_rdata;
endmodule

// File: tb/tb_lm_sm_seq.sv
// Directed and random LM/SM instructions checked cycle by cycle against a
// mask-walk reference list built in the bench.
module tb_lm_sm_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [15:0] mem_key = 16'hA000;
    logic [15:0] rf_key  = 16'h0000;

    lm_sm_seq_if #(.DATA_W(16), .ADDR_W(16), .NREG(8)) ifc ();

    lm_sm_seq #(.DATA_W(16), .ADDR_W(16), .NREG(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    // Combinational-read memory and register file stand-ins.
    assign ifc.mem_rdata = mem_key + ifc.mem_addr;
    assign ifc.rf_rdata  = rf_key ^ (16'h1111 * {13'd0, ifc.rf_addr});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".busy"},   32'(ifc.busy),   0);
        chk({tag, ".rf_we"},  32'(ifc.rf_we),  0);
        chk({tag, ".mem_re"}, 32'(ifc.mem_re), 0);
        chk({tag, ".mem_we"}, 32'(ifc.mem_we), 0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_instr(input string tag, input logic ld, input logic [7:0] m,
                            input logic [15:0] b, input logic [15:0] mkey,
                            input logic [15:0] rkey, input bit noise);
        int          regs[$];
        logic [15:0] ea;
        for (int i = 0; i < 8; i++) if (m[i]) regs.push_back(i);
        mem_key       = mkey;
        rf_key        = rkey;
        ifc.start     = 1'b1;
        ifc.is_load   = ld;
        ifc.mask      = m;
        ifc.base_addr = b;
        @(negedge clk);
        ifc.start     = noise;
        ifc.mask      = noise ? 8'h80 : 8'($urandom);
        ifc.base_addr = 16'($urandom);
        ifc.is_load   = ~ld;
        for (int k = 0; k < regs.size(); k++) begin
            ea = b + 16'(k);
            chk({tag, ".x.busy"},     32'(ifc.busy),     1);
            chk({tag, ".x.done"},     32'(ifc.done),     0);
            chk({tag, ".x.rf_addr"},  32'(ifc.rf_addr),  32'(regs[k]));
            chk({tag, ".x.mem_addr"}, 32'(ifc.mem_addr), 32'(ea));
            chk({tag, ".x.rf_we"},    32'(ifc.rf_we),    32'(ld));
            chk({tag, ".x.mem_re"},   32'(ifc.mem_re),   32'(ld));
            chk({tag, ".x.mem_we"},   32'(ifc.mem_we),   32'(!ld));
            if (ld) chk({tag, ".x.rf_wdata"}, 32'(ifc.rf_wdata), 32'(16'(mkey + ea)));
            else    chk({tag, ".x.mem_wdata"}, 32'(ifc.mem_wdata),
                        32'(rkey ^ 16'(16'h1111 * regs[k])));
            @(negedge clk);
        end
        chk({tag, ".done"}, 32'(ifc.done), 1);
        chk_quiet({tag, ".d"});
        @(negedge clk);
        chk({tag, ".idle.done"}, 32'(ifc.done), 0);
        chk_quiet({tag, ".i"});
        ifc.start = 1'b0;
    endtask

    initial begin
        ifc.start     = 1'b1;
        ifc.is_load   = 1'b1;
        ifc.mask      = 8'hFF;
        ifc.base_addr = 16'h1234;
        repeat (2) @(negedge clk);
        chk("rst.done",     32'(ifc.done),     0);
        chk("rst.rf_addr",  32'(ifc.rf_addr),  0);
        chk("rst.mem_addr", 32'(ifc.mem_addr), 0);
        chk_quiet("rst");
        ifc.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_instr("t1_lm",   1'b1, 8'b1001_0100, 16'h0040, 16'hA000, 16'h0000, 1'b0);
        do_instr("t2_sm",   1'b0, 8'hFF,        16'h0100, 16'hA000, 16'h0000, 1'b0);
        do_instr("t3_zero", 1'b1, 8'h00,        16'h0300, 16'hA000, 16'h0000, 1'b0);
        do_instr("t4_wrap", 1'b1, 8'h07,        16'hFFFE, 16'hA000, 16'h0000, 1'b0);

        // Reset in the middle of the second transfer of an LM 0xFF.
        ifc.start = 1'b1; ifc.is_load = 1'b1; ifc.mask = 8'hFF; ifc.base_addr = 16'h0200;
        @(negedge clk);
        ifc.start = 1'b0;
        chk("t5.x1.rf_addr", 32'(ifc.rf_addr), 0);
        @(negedge clk);
        chk("t5.x2.rf_addr",  32'(ifc.rf_addr),  1);
        chk("t5.x2.mem_addr", 32'(ifc.mem_addr), 32'h0201);
        chk("t5.x2.rf_we",    32'(ifc.rf_we),    1);
        #2 rst = 1'b0;
        ifc.start = 1'b1;
        #1;
        chk("t5.abort.done",     32'(ifc.done),     0);
        chk("t5.abort.rf_addr",  32'(ifc.rf_addr),  0);
        chk("t5.abort.mem_addr", 32'(ifc.mem_addr), 0);
        chk_quiet("t5.abort");
        @(negedge clk);
        chk_quiet("t5.held");
        ifc.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("t5.post");
        do_instr("t5_sm1", 1'b0, 8'h01, 16'h0500, 16'hA000, 16'h0000, 1'b0);

        do_instr("t6_noise", 1'b0, 8'h03, 16'h0600, 16'hA000, 16'h0000, 1'b1);
        do_instr("t6_next",  1'b1, 8'h80, 16'h0700, 16'h5000, 16'h0000, 1'b0);

        for (int r = 0; r < 12; r++) begin
            logic [7:0] m;
            m = (r % 5 == 4) ? 8'h00 : 8'($urandom);
            do_instr("rnd", 1'($urandom), m, 16'($urandom), 16'($urandom),
                     16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/lm_sm_seq.md
Name: lm_sm_seq

Overview:
Multi-register transfer sequencer for the LM (load multiple) and SM (store multiple) instructions. It drives the register file and data memory ports for these instructions. For each set bit of an 8-bit register mask, in ascending register order, it issues one register access and one memory access per cycle. It sits in the execute/memory stage, takes the register file's write and read ports for the duration of the instruction, and holds busy high so the pipeline stalls.

Parameters:
DATA_W, 16, register and memory data width
ADDR_W, 16, memory address width
NREG, 8, number of architectural registers (mask width); register index width is 3

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
start  input  1  request a transfer; sampled only in IDLE
is_load  input  1  1 = LM (memory -> registers), 0 = SM (registers -> memory); latched at start
mask  input  8  register select, bit i = Ri; latched at start
base_addr  input  16  first memory address; latched at start
busy  output  1  high while in XFER; used as the pipeline stall request
done  output  1  one-cycle pulse when the instruction completes
rf_addr  output  3  register index for the current transfer (write dest for LM, read addr for SM)
rf_we  output  1  register file write enable (LM transfers only)
rf_wdata  output  16  combinational copy of mem_rdata
rf_rdata  input  16  register file read data (SM)
mem_addr  output  16  memory address for the current transfer
mem_re  output  1  memory read strobe (LM)
mem_we  output  1  memory write strobe (SM)
mem_rdata  input  16  memory read data, combinational-read memory
mem_wdata  output  16  combinational copy of rf_rdata

Behaviour:
- rst low, at any time (async): state=IDLE; pending mask=0; address register=0; is_load latch=0. Outputs: busy, done, rf_we, mem_re, mem_we=0; rf_addr=0; mem_addr=0. While rst is low, start is ignored.
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - All strobes are low.
  - start=1 with mask!=0: latch mask into pending, base_addr into addr, and is_load. Next state is XFER.
  - start=1 with mask=0: next state is DONE. No accesses are issued.
- XFER: busy=1. cur = index of the lowest set bit of pending (priority encoder, R0 first). rf_addr=cur and mem_addr=addr.
  - LM: mem_re=1 and rf_we=1. rf_wdata=mem_rdata in the same cycle.
  - SM: mem_we=1 and mem_wdata=rf_rdata in the same cycle.
  - On the clock edge: clear pending[cur]; addr <= addr+1 modulo 2^16 (0xFFFF wraps to 0x0000).
  - If pending has exactly one bit set, the next state is DONE; otherwise stay in XFER.
- DONE: done=1 and busy=0, all strobes low, for exactly one cycle. Next state is IDLE.
- Latency: K set mask bits give K consecutive XFER cycles starting the cycle after start is accepted. done is high in cycle K+1 after acceptance, or in cycle 1 if mask=0.
- Strobes are never asserted outside XFER. rf_we and mem_we are never high together.
- start is ignored in XFER and DONE. Mask, base and direction cannot change mid-instruction.
- Reset mid-operation aborts immediately. Transfers already completed are not undone, and no further strobes are issued.
- rf_addr and mem_addr are decoded from registered state only; they are glitch-free within the cycle.

Test Plan:
1. LM, mask=8'b1001_0100, base=0x0040, mem_rdata=0xA000+addr.
   -> Three XFER cycles: (rf_addr=2, mem_addr 0x0040), (4, 0x0041), (7, 0x0042).
   -> rf_we and mem_re high in all three; rf_wdata=0xA040/0xA041/0xA042.
   -> done pulses in cycle 4; busy high in cycles 1-3 only.
2. SM, mask=0xFF, base=0x0100, rf_rdata=0x1111*rf_addr.
   -> Eight cycles with rf_addr 0..7 and mem_addr 0x0100..0x0107.
   -> mem_we high and mem_wdata tracking rf_rdata each cycle; rf_we never high; done in cycle 9.
3. start with mask=0x00 -> no strobes at any time; busy stays 0; done=1 in the cycle after start, then IDLE.
4. LM, base=0xFFFE, mask=0x07 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000 for R0, R1, R2; done in cycle 4.
5. LM with mask=0xFF, rst driven low mid-cycle during the 2nd transfer.
   -> Strobes and busy drop to 0 without waiting for a clock edge.
   -> After rst returns high, a new SM with mask=0x01 completes normally (1 transfer, done in cycle 2).
6. SM with mask=0x03 accepted; start re-asserted with mask=0x80 during XFER and DONE.
   -> Both re-assertions ignored: only R0 and R1 are transferred.
   -> Next start, given after returning to IDLE, is accepted.
